seq_sub_abs_32bit: RTL and testbench
====================================

Name: seq_sub_abs_32bit

Overview:
- Multi-cycle 32-bit subtractor that computes A − B in CHUNK-bit slices and, when the signed result is negative, converts it to magnitude in a second sliced pass.
- Counterpart to the ALU's combinational adder/magnitude path: it subtracts where that path adds.
- Sits beside the ALU as a low-area arithmetic unit with a start/done handshake.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per clock; NSLICE = WIDTH/CHUNK (default 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; latched on an accepted start.
- B  input  WIDTH  subtrahend; latched on an accepted start.
- busy  output  1  high from the accepting edge until done is asserted.
- done  output  1  one-cycle pulse; all results valid from this cycle onward.
- diff  output  WIDTH  A − B mod 2^WIDTH.
- borrow  output  1  unsigned A < B.
- ovf  output  1  signed overflow of A − B.
- zero  output  1  diff == 0.
- neg  output  1  true sign of signed A − B, i.e. diff[MSB] XOR ovf.
- mag  output  WIDTH  |A − B| for signed operands, unsigned; always fits (max 2^WIDTH − 1).

Behaviour:
- Reset (asynchronous, any state): state = IDLE. busy, done, diff, borrow, ovf, zero, neg and mag all clear to 0. Internal slice counter and carry clear to 0.
- IDLE:
  - start=1 at an edge latches A and B, clears the slice counter, sets carry-in to 1 (two's-complement subtract as A + ~B + 1), sets busy, and moves to SUB.
  - start=0 keeps the state in IDLE.
- SUB, NSLICE edges:
  - Each edge adds slice k of A and ~B plus the running carry, writes diff[k], and increments k. The low slice goes first.
  - On the last slice: borrow = NOT carry-out; ovf = (A[MSB] != B[MSB]) AND (diff[MSB] != A[MSB]); zero and neg are computed.
  - If neg=0, go to DONE and set mag = diff.
  - If neg=1, go to ABS with carry = 1 and k = 0.
- ABS, NSLICE edges:
  - Each edge adds slice k of ~diff plus the carry into mag[k], so that mag = −diff mod 2^WIDTH.
  - After the last slice, go to DONE.
- DONE, 1 cycle:
  - done = 1 and busy = 0 in this cycle.
  - Next edge returns to IDLE; done drops to 0.
- Latency, counted from the edge that accepts start to the first cycle in which done is high:
  - NSLICE + 1 edges when neg=0 (5 by default).
  - 2·NSLICE + 1 edges when neg=1 (9 by default).
- Result registers hold their values after done until the next accepted start. They are not cleared when the block returns to IDLE.
- start while busy=1 or in DONE is ignored. No queuing takes place, and the latched operands do not change.
- start held high continuously: a new operation is accepted on the first edge back in IDLE, i.e. one cycle after done.
- Reset mid-operation aborts the operation immediately. No done is produced. All outputs are 0 after reset.
- Operand changes on A/B after acceptance have no effect.

Test Plan:
- A=5, B=3, start pulse → done 5 edges later; diff=0x00000002, borrow=0, ovf=0, zero=0, neg=0, mag=2.
- A=3, B=5 → done 9 edges later; diff=0xFFFFFFFE, borrow=1, ovf=0, neg=1, mag=0x00000002.
- A=0x7FFFFFFF, B=0xFFFFFFFF → diff=0x80000000, ovf=1, borrow=1, neg=0, mag=0x80000000, latency 5.
- A=0x80000000, B=0x7FFFFFFF → diff=0x00000001, ovf=1, neg=1, mag=0xFFFFFFFF, latency 9. Then A=B=0x12345678 → diff=0, zero=1, borrow=0, mag=0.
- start asserted again on the 2nd busy cycle with different A/B → ignored; results match the first operands. Hold start high → the next operation is accepted one cycle after done.
- rst_n low for 1 cycle during ABS → busy, done, diff and mag read 0 immediately; no done pulse. A fresh start afterwards completes with the correct results.

Source files
------------

// File: rtl/seq_sub_abs_32bit.sv
// Multi-cycle subtractor: computes A - B one CHUNK-bit slice per clock, then,
// when the true signed result is negative, a second sliced pass that turns
// diff into its magnitude. A start/done handshake frames each operation.
// WIDTH must be an exact multiple of CHUNK.
module seq_sub_abs_32bit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [WIDTH-1:0] mag
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        ABS,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [KW-1:0]    k;
    logic             carry;

    int               base;
    logic [CHUNK:0]   sub_sum;
    logic [CHUNK:0]   abs_sum;
    logic [WIDTH-1:0] diff_nxt;
    logic             ovf_nxt;
    logic             neg_nxt;
    logic             last;

    // Slice adders for both passes plus the flags seen on the final SUB slice.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        base     = int'(k) * CHUNK;
        sub_sum  = {1'b0, a_q[base +: CHUNK]} + {1'b0, ~b_q[base +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry};
        abs_sum  = {1'b0, ~diff[base +: CHUNK]} + {{CHUNK{1'b0}}, carry};
        diff_nxt = diff;
        diff_nxt[base +: CHUNK] = sub_sum[CHUNK-1:0];
        ovf_nxt  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
        neg_nxt  = diff_nxt[WIDTH-1] ^ ovf_nxt;
        last     = (k == LAST);
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: SUB branches to ABS only for a negative true result.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = SUB;
            SUB:  if (last)  state_nxt = neg_nxt ? ABS : DONE;
            ABS:  if (last)  state_nxt = DONE;
            DONE:            state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, slice-by-slice subtract, then magnitude pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            k      <= '0;
            carry  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            mag    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        k     <= '0;
                        carry <= 1'b1;  // A + ~B + 1
                    end
                end
                SUB: begin
                    diff  <= diff_nxt;
                    carry <= sub_sum[CHUNK];
                    k     <= k + KW'(1);
                    if (last) begin
                        borrow <= ~sub_sum[CHUNK];
                        ovf    <= ovf_nxt;
                        zero   <= (diff_nxt == '0);
                        neg    <= neg_nxt;
                        k      <= '0;
                        if (neg_nxt) carry <= 1'b1;  // -diff = ~diff + 1
                        else         mag   <= diff_nxt;
                    end
                end
                ABS: begin
                    mag[base +: CHUNK] <= abs_sum[CHUNK-1:0];
                    carry <= abs_sum[CHUNK];
                    k     <= last ? '0 : k + KW'(1);
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs decode directly from the state.
    assign busy = (state == SUB) || (state == ABS);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_sub_abs_32bit.sv
// Self-checking bench for seq_sub_abs_32bit: directed corner cases, protocol
// cases (ignored start, held start, mid-operation reset) and random operands
// compared against a plain-arithmetic reference model.
module tb_seq_sub_abs_32bit;

    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, borrow, ovf, zero, neg;
    logic [W-1:0] diff, mag;

    int n_checks = 0;
    int n_fail   = 0;

    seq_sub_abs_32bit #(.WIDTH(W), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow),
        .ovf(ovf), .zero(zero), .neg(neg), .mag(mag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: 33-bit signed arithmetic gives the true difference directly.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] d, output logic [W-1:0] m,
                                  output logic bo, output logic ov,
                                  output logic z, output logic ng);
        logic signed [W:0] s;
        s  = $signed({a[W-1], a}) - $signed({b[W-1], b});
        d  = a - b;
        bo = (a < b);
        ov = (s[W] != s[W-1]);
        ng = s[W];
        z  = (d == '0);
        m  = ng ? W'(-s) : W'(s);
    endfunction

    task automatic check_results(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d, m;
        logic bo, ov, z, ng;
        model(a, b, d, m, bo, ov, z, ng);
        check({tag, ".diff"},   diff, d);
        check({tag, ".borrow"}, W'(borrow), W'(bo));
        check({tag, ".ovf"},    W'(ovf), W'(ov));
        check({tag, ".zero"},   W'(zero), W'(z));
        check({tag, ".neg"},    W'(neg), W'(ng));
        check({tag, ".mag"},    mag, m);
    endtask

    // Edges counted from the accepting edge (inclusive) up to done; bounded.
    task automatic wait_done(output int edges, input bit poke_start);
        edges = 1;
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (poke_start && edges == 2) begin
                start = 1'b1;
                A = $urandom;
                B = $urandom;
            end else if (poke_start && edges == 3) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke_start);
        logic [W-1:0] d, m;
        logic bo, ov, z, ng;
        int edges;
        model(a, b, d, m, bo, ov, z, ng);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy_on_accept"}, W'(busy), W'(1));
        A = $urandom;   // operands after acceptance must not matter
        B = $urandom;
        wait_done(edges, poke_start);
        check({tag, ".latency"}, W'(edges), W'(ng ? 2 * N + 1 : N + 1));
        check({tag, ".busy_at_done"}, W'(busy), W'(0));
        check_results(tag, a, b);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, W'(done), W'(0));
        check_results({tag, ".held"}, a, b);
    endtask

    initial begin
        int edges;
        logic [W-1:0] ra, rb;

        #1;
        check("reset.busy", W'(busy), W'(0));
        check("reset.done", W'(done), W'(0));
        check("reset.diff", diff, '0);
        check("reset.mag",  mag,  '0);
        check("reset.flags", W'({borrow, ovf, zero, neg}), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("pos",      32'd5,         32'd3,         1'b0);
        run_op("neg",      32'd3,         32'd5,         1'b0);
        run_op("ovf_pos",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("ovf_neg",  32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        run_op("equal",    32'h1234_5678, 32'h1234_5678, 1'b0);
        run_op("ignore",   32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
        run_op("ignore_n", 32'h0000_0001, 32'hDEAD_BEEF, 1'b1);

        // Held start: next operation is accepted on the first edge back in IDLE.
        @(negedge clk);
        A = 32'd100; B = 32'd40; start = 1'b1;
        @(posedge clk); #1;
        wait_done(edges, 1'b0);
        check("hold.latency", W'(edges), W'(N + 1));
        check_results("hold.first", 32'd100, 32'd40);
        A = 32'd40; B = 32'd100;
        @(posedge clk); #1;
        check("hold.idle_gap_busy", W'(busy), W'(0));
        check("hold.idle_gap_done", W'(done), W'(0));
        @(posedge clk); #1;
        check("hold.reaccept_busy", W'(busy), W'(1));
        start = 1'b0;
        wait_done(edges, 1'b0);
        check("hold.second_latency", W'(edges), W'(2 * N + 1));
        check_results("hold.second", 32'd40, 32'd100);

        // Reset during ABS aborts with all outputs cleared and no done.
        @(negedge clk);
        A = 32'd3; B = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (N + 2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst.busy", W'(busy), W'(0));
        check("rst.done", W'(done), W'(0));
        check("rst.diff", diff, '0);
        check("rst.mag",  mag,  '0);
        check("rst.flags", W'({borrow, ovf, zero, neg}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(posedge clk); #1;
            if (done) edges++;
        end
        check("rst.no_done", W'(edges), W'(0));
        run_op("post_rst", 32'd3, 32'd5, 1'b0);

        // Random operands, with occasional equal and sign-boundary pairs.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: ra = {~rb[W-1], ra[W-2:0]};
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
